wport_arbiter: RTL
==================

# wport_arbiter

Round-robin arbiter that shares the register file's single write port among eight requesters (ALU writeback, load return, multiplier/divider completion, etc.). It grants one requester at a time and presents the grant as both a 3-bit index and a one-hot write-enable vector, which gates the register file's per-register write decode. The grant is registered and locked while the owner holds its request.

## Interface
- `MAX_HOLD`, default 16: cycles an owner may hold the grant before preemption; used only with the timeout feature; legal range 2..255.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 8: request per requester; bit i is held high for as long as requester i needs the port.
- `grant` output 8: one-hot grant; all zeros when idle.
- `grant_idx` output 3: index of the current owner; 0 when idle.
- `grant_valid` output 1: high when any grant is active.
- `preempt` output 1: single-cycle pulse on the cycle a timeout revokes a grant. Held at 0 when the timeout feature is compiled out.

## Operation
- State is `owner_valid`, `owner[2:0]`, `last[2:0]` (round-robin pointer) and, with the timeout feature, `hold_cnt[7:0]`.
- Reset values: `grant`=0, `grant_idx`=0, `grant_valid`=0, `preempt`=0, `last`=7 (so requester 0 has first priority), `hold_cnt`=0.
- **IDLE** (`owner_valid`=0):
  - If any `req` bit is high, pick the first set bit scanning `last+1`, `last+2`, … modulo 8.
  - Next state is GRANTED with `owner` = `last` = the picked index and `hold_cnt`=1.
- **GRANTED**:
  - If `req[owner]` drops, the grant is released. If other requests are pending, re-arbitrate on the same edge starting at `owner+1`, with no dead cycle. Otherwise return to IDLE.
  - If `req[owner]` stays high, keep the grant and increment `hold_cnt`, saturating at 255.
- **Timeout** (feature compiled in): when `hold_cnt` == `MAX_HOLD` and `req[owner]` is still high:
  - Re-arbitrate starting at `owner+1`; the current owner is included in the scan but has the lowest priority.
  - Pulse `preempt` for one cycle.
  - If no other request is pending, the same owner is re-granted with `hold_cnt`=1, and `preempt` still pulses.
- `grant` is always the one-hot decode of `grant_idx`, qualified by `grant_valid`. It never has more than one bit set.
- Request bits that rise or fall in the same cycle as a grant change are sampled at that edge only. There is no combinational path from `req` to any output.

## Timing
- Latency: a request sampled high at edge N, with the port free, produces a grant visible after edge N, i.e. usable in cycle N+1.
- Release: `req[owner]` low at edge N means the grant is deasserted, or handed over, after edge N.
- Back-to-back handover costs zero idle cycles.
- All outputs are registered.
- Reset asserted mid-grant clears all state immediately, without waiting for a clock edge. After reset is released, the first arbitration starts from requester 0.

## Configuration
- `WPORT_ARB_TIMEOUT_EN` defined:
  - The `hold_cnt` counter and the preemption logic are built.
  - `preempt` is driven as described in Operation.
- Not defined:
  - Grants are held indefinitely while `req[owner]` is high.
  - `hold_cnt` is removed.
  - `preempt` is tied to 0.
  - `MAX_HOLD` is ignored.

## Structure
- Shared package holds:
  - `WPORT_N`=8, `WPORT_IDX_W`=3 and `HOLD_CNT_W`=8.
  - The state encoding `WPORT_IDLE`=1'b0 and `WPORT_GRANTED`=1'b1.
- One sub-module, `rr_pick8`: combinational round-robin picker.
  - Inputs: `req[7:0]` and `start[2:0]`.
  - Outputs: `found` and `idx[2:0]`.
  - Implementation: rotate-and-priority-encode. It is instantiated once; the top level supplies `start` as `last+1` or `owner+1`.

## Test plan
- **Single request:** reset, then `req`=8'h04 → after one edge `grant`=8'h04, `grant_idx`=2, `grant_valid`=1. Drop `req` → next edge `grant`=0, `grant_valid`=0.
- **Rotation:** hold `req`=8'hFF and each owner drops and re-raises after 2 cycles → grants are issued in order 0,1,2,…,7,0 with no idle cycle between them.
- **Lock:** owner 5 is granted, then `req`=8'h21 is held for 10 cycles (timeout compiled out) → `grant` stays 8'h20 throughout. Requester 0 is granted on the edge after bit 5 drops.
- **Timeout (`WPORT_ARB_TIMEOUT_EN`, `MAX_HOLD`=4):** `req`=8'h03 held constantly → the grant alternates between 0 and 1 every 4 cycles, with a `preempt` pulse at each switch. With `req`=8'h01 only, requester 0 is re-granted every 4 cycles and `preempt` still pulses.
- **Reset mid-grant:** with owner 3 active, drive `reset_n` low between clock edges → all outputs are 0 immediately. After release, with `req`=8'h09, requester 0 is granted first.

Source files
------------

// File: rtl/wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wport_arbiter_pkg;

  localparam int unsigned WPORT_N     = 8;
  localparam int unsigned WPORT_IDX_W = 3;
  localparam int unsigned HOLD_CNT_W  = 8;

  typedef enum logic {
    WPORT_IDLE    = 1'b0,
    WPORT_GRANTED = 1'b1
  } wport_state_e;

  // One-hot decode of a requester index.
  function automatic logic [WPORT_N-1:0] onehot_idx(input logic [WPORT_IDX_W-1:0] i);
    return WPORT_N'(1) << i;
  endfunction

endpackage

// File: rtl/wport_arbiter_rr_pick8.sv
// rr_pick8: combinational round-robin picker. Returns the first set request
// bit found scanning start, start+1, ... modulo 8.
module rr_pick8
  import wport_arbiter_pkg::*;
(
  input  logic [WPORT_N-1:0]     req,
  input  logic [WPORT_IDX_W-1:0] start,
  output logic                   found,
  output logic [WPORT_IDX_W-1:0] idx
);

  logic [WPORT_N-1:0]     rot;
  logic [WPORT_IDX_W-1:0] off;

  // Rotate so that position 0 corresponds to the scan start.
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < WPORT_N; i++) begin
      rot[i] = req[start + WPORT_IDX_W'(i)];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    off = '0;
    for (int unsigned i = 0; i < WPORT_N; i++) begin
      if (rot[WPORT_N-1-i]) off = WPORT_IDX_W'(WPORT_N-1-i);
    end
  end

  assign found = |req;
  assign idx   = start + off;

endmodule

// File: rtl/wport_arbiter.sv
// wport_arbiter: round-robin arbiter for the register file's single write
// port, eight requesters, registered and locked grant.
// Optional macro WPORT_ARB_TIMEOUT_EN builds the hold counter and the
// MAX_HOLD preemption; without it grants are held indefinitely.
module wport_arbiter
  import wport_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WPORT_N-1:0]     req,
  output logic [WPORT_N-1:0]     grant,
  output logic [WPORT_IDX_W-1:0] grant_idx,
  output logic                   grant_valid,
  output logic                   preempt
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("wport_arbiter: MAX_HOLD must be in 2..255");
  end

  wport_state_e           state, state_nxt;
  logic [WPORT_IDX_W-1:0] owner, owner_nxt;
  logic [WPORT_IDX_W-1:0] last, last_nxt;
  logic [WPORT_N-1:0]     grant_nxt;
  logic [WPORT_IDX_W-1:0] grant_idx_nxt;
  logic                   take;
  logic                   timeout;
  logic                   pick_found;
  logic [WPORT_IDX_W-1:0] pick_idx;
  logic [WPORT_IDX_W-1:0] pick_start;

  // While granted last == owner, so both starts agree; kept explicit for clarity.
  assign pick_start = (state == WPORT_GRANTED) ? owner + 3'd1 : last + 3'd1;

  rr_pick8 u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef WPORT_ARB_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_nxt;

  assign timeout = (state == WPORT_GRANTED) && req[owner] &&
                   (hold_cnt == HOLD_CNT_W'(MAX_HOLD));

  // Hold counter: restarts at 1 on every (re)grant, otherwise saturating count.
  always_comb begin
    hold_nxt = hold_cnt;
    if (take) hold_nxt = HOLD_CNT_W'(1);
    else if (state == WPORT_GRANTED && hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
  end

  // Hold counter and preempt pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      preempt  <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign preempt = 1'b0;
`endif

  // Next-state: new grant from idle, release/handover, or timeout re-arbitration.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    take      = 1'b0;
    case (state)
      WPORT_IDLE: begin
        if (pick_found) begin
          state_nxt = WPORT_GRANTED;
          owner_nxt = pick_idx;
          last_nxt  = pick_idx;
          take      = 1'b1;
        end
      end
      WPORT_GRANTED: begin
        if (!req[owner] || timeout) begin
          if (pick_found) begin
            owner_nxt = pick_idx;
            last_nxt  = pick_idx;
            take      = 1'b1;
          end else begin
            state_nxt = WPORT_IDLE;
          end
        end
      end
    endcase
    grant_idx_nxt = (state_nxt == WPORT_GRANTED) ? owner_nxt : '0;
    grant_nxt     = (state_nxt == WPORT_GRANTED) ? onehot_idx(owner_nxt) : '0;
  end

  // State and registered grant outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WPORT_IDLE;
      owner     <= '0;
      last      <= 3'd7;
      grant     <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      grant     <= grant_nxt;
      grant_idx <= grant_idx_nxt;
    end
  end

  assign grant_valid = (state == WPORT_GRANTED);

endmodule
